// File: rtl/aes_key_schedule.sv
// aes_key_schedule: sequential AES-128/192/256 key expansion (one word per clock) with a registered round-key read port.
// Optional define AES_KS_DEC_ORDER_EN presents round keys in reverse (decryption) order on the read port.

module AesSbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    logic [7:0] y;
    acc = 8'h00;
    x   = a;
    y   = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) acc = acc ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return acc;
  endfunction

  // Inverse taken as a^254 (a^2 * a^4 * ... * a^128), so zero maps to zero.
  function automatic logic [7:0] subByte(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gfMul(sq, sq);
      inv = gfMul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign out_o = subByte(in_i);

endmodule

module aes_key_schedule #(
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
);

  localparam int NR = NK + 6;
  localparam int TW = 4 * (NR + 1);

  localparam logic [5:0] NK_W    = 6'(NK);
  localparam logic [5:0] TW_LAST = 6'(TW - 1);
  localparam logic [2:0] PH_LAST = 3'(NK - 1);
  localparam logic [3:0] NR_R    = 4'(NR);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_badNk
    $error("aes_key_schedule: NK must be 4, 6 or 8");
  end

  typedef enum logic {
    IDLE,
    EXPAND
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    wordIdx_q, wordIdx_d;
  logic [2:0]    phase_q, phase_d;
  logic [7:0]    rcon_q, rcon_d;
  logic          done_q, done_d;
  logic          keyValid_q, keyValid_d;
  logic [127:0]  rdKey_q, rdKey_d;

  logic [31:0]   words_q [TW];

  logic          loadKey;
  logic          wrEn;
  logic [31:0]   prevWord;
  logic [31:0]   farWord;
  logic [31:0]   subIn;
  logic [31:0]   subOut;
  logic [31:0]   tWord;
  logic [31:0]   newWord;
  logic [3:0]    roundSel;
  logic [5:0]    rdBase;
  logic          unusedKeyBits;

  // Only the leading NK words of key_in matter; the rest is deliberately ignored.
  assign unusedKeyBits = ^key_in;

  assign prevWord = words_q[wordIdx_q - 6'd1];
  assign farWord  = words_q[wordIdx_q - NK_W];
  assign subIn    = (phase_q == 3'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    AesSbox u_sbox (
      .in_i  (subIn[8*b +: 8]),
      .out_o (subOut[8*b +: 8])
    );
  end

  always_comb begin
    tWord = prevWord;
    if (phase_q == 3'd0) begin
      tWord = subOut ^ {rcon_q, 24'h000000};
    end else if (NK == 8 && phase_q == 3'd4) begin
      tWord = subOut;
    end
  end

  assign newWord = farWord ^ tWord;

  always_comb begin
    state_d    = state_q;
    wordIdx_d  = wordIdx_q;
    phase_d    = phase_q;
    rcon_d     = rcon_q;
    done_d     = 1'b0;
    keyValid_d = keyValid_q;
    loadKey    = 1'b0;
    wrEn       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          loadKey    = 1'b1;
          state_d    = EXPAND;
          wordIdx_d  = NK_W;
          phase_d    = 3'd0;
          rcon_d     = 8'h01;
          keyValid_d = 1'b0;
        end
      end
      EXPAND: begin
        wrEn      = 1'b1;
        wordIdx_d = wordIdx_q + 6'd1;
        phase_d   = (phase_q == PH_LAST) ? 3'd0 : phase_q + 3'd1;
        if (phase_q == 3'd0) begin
          rcon_d = rcon_q[7] ? ({rcon_q[6:0], 1'b0} ^ 8'h1b) : {rcon_q[6:0], 1'b0};
        end
        if (wordIdx_q == TW_LAST) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          keyValid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wordIdx_q  <= 6'd0;
      phase_q    <= 3'd0;
      rcon_q     <= 8'h01;
      done_q     <= 1'b0;
      keyValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wordIdx_q  <= wordIdx_d;
      phase_q    <= phase_d;
      rcon_q     <= rcon_d;
      done_q     <= done_d;
      keyValid_q <= keyValid_d;
    end
  end

  // The word store carries no reset; its contents only matter once key_valid is set.
  always_ff @(posedge clk) begin
    if (loadKey) begin
      for (int k = 0; k < NK; k++) begin
        words_q[k] <= key_in[255 - 32*k -: 32];
      end
    end else if (wrEn) begin
      words_q[wordIdx_q] <= newWord;
    end
  end

`ifdef AES_KS_DEC_ORDER_EN
  assign roundSel = NR_R - rd_round;
`else
  assign roundSel = rd_round;
`endif

  assign rdBase = {roundSel, 2'b00};

  always_comb begin
    rdKey_d = 128'h0;
    if (keyValid_q && rd_round <= NR_R) begin
      rdKey_d = {words_q[rdBase], words_q[rdBase + 6'd1],
                 words_q[rdBase + 6'd2], words_q[rdBase + 6'd3]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdKey_q <= 128'h0;
    end else begin
      rdKey_q <= rdKey_d;
    end
  end

  assign busy      = (state_q == EXPAND);
  assign done      = done_q;
  assign key_valid = keyValid_q;
  assign rd_key    = rdKey_q;

endmodule
